// File: rtl/register_file_if.sv
// Writeback bus from the WB stage into the register file: enable, destination index and data.
interface register_file_if #(
  parameter int XLEN = 32
);
  logic            i_wback;
  logic [4:0]      i_wreg;
  logic [XLEN-1:0] i_wdata;

  modport master (output i_wback, i_wreg, i_wdata);
  modport slave  (input  i_wback, i_wreg, i_wdata);
endinterface

// File: rtl/register_file.sv
// Decode/register-read stage: 32x32 integer register file with a registered operand bundle.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback into the captured operands.
package Common;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] reg1;
    logic [31:0] reg2;
  } Signals;
endpackage

module register_file #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int DEBUG_REG = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  Common::Signals     i_buffer,
  register_file_if.slave     wb,
  output Common::Signals     o_signals,
  output logic [XLEN-1:0]    o_debug
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [XLEN-1:0] registers [0:NREGS-1];

  Common::Signals  signals_q, signals_d;
  logic [4:0]      rs1, rs2;
  logic [6:0]      opcode;
  logic            useRs1, useRs2, writeEn;
  logic [XLEN-1:0] rdata1, rdata2;

  assign rs1     = i_buffer.insn[19:15];
  assign rs2     = i_buffer.insn[24:20];
  assign opcode  = i_buffer.insn[6:0];
  assign writeEn = wb.i_wback && (wb.i_wreg != 5'd0);

  always_comb begin
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        useRs1 = 1'b1;
        useRs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: useRs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 is hardwired to zero on the read side as well as being write-protected.
  always_comb begin
    rdata1 = (rs1 == 5'd0) ? '0 : registers[rs1];
    rdata2 = (rs2 == 5'd0) ? '0 : registers[rs2];
`ifdef REGFILE_BYPASS_EN
    if (writeEn && (wb.i_wreg == rs1)) rdata1 = wb.i_wdata;
    if (writeEn && (wb.i_wreg == rs2)) rdata2 = wb.i_wdata;
`endif
  end

  always_comb begin
    signals_d      = i_buffer;
    signals_d.reg1 = useRs1 ? rdata1 : '0;
    signals_d.reg2 = useRs2 ? rdata2 : '0;
  end

  // Writes land even while the stage is stalled; reset wins over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) registers[i] <= '0;
    end else if (writeEn) begin
      registers[wb.i_wreg] <= wb.i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      signals_q <= '0;
    end else if (!stall) begin
      signals_q <= signals_d;
    end
  end

  assign o_signals = signals_q;
  assign o_debug   = registers[DEBUG_REG];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed register-read cases followed by randomized
// cycles compared against an array-based reference model (honours REGFILE_BYPASS_EN).
module tb_register_file;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst, stall;
  Common::Signals iBuffer, oSignals;
  logic [XLEN-1:0] oDebug;

  register_file_if #(.XLEN(XLEN)) wbIf ();

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .i_buffer (iBuffer),
    .wb       (wbIf),
    .o_signals(oSignals),
    .o_debug  (oDebug)
  );

  always #5 clk = ~clk;

  logic [31:0]    model [32];
  Common::Signals expSignals;
  int checks = 0;
  int errors = 0;

  logic [6:0] opList [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
                              7'b1111111};

  // Compares one observed value against the model's expectation and tallies the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit readsRs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit readsRs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  // Architectural value of register idx as seen by a read in a cycle carrying the given writeback.
  function automatic logic [31:0] modelRead(input logic [4:0] idx, input logic wb,
                                            input logic [4:0] wreg, input logic [31:0] wdata);
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb && wreg == idx) return wdata;
`endif
    return model[idx];
  endfunction

  // Drives one cycle, predicts the outcome from the model, then checks after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [31:0] pc,
                               input logic [31:0] insn, input logic wb,
                               input logic [4:0] wreg, input logic [31:0] wdata);
    logic [6:0] op;
    logic [4:0] a, b;
    rst = r;
    stall = s;
    iBuffer = '0;
    iBuffer.pc = pc;
    iBuffer.insn = insn;
    wbIf.i_wback = wb;
    wbIf.i_wreg = wreg;
    wbIf.i_wdata = wdata;
    op = insn[6:0];
    a = insn[19:15];
    b = insn[24:20];
    if (r) begin
      expSignals = '0;
    end else if (!s) begin
      expSignals.pc = pc;
      expSignals.insn = insn;
      expSignals.reg1 = readsRs1(op) ? modelRead(a, wb, wreg, wdata) : 32'd0;
      expSignals.reg2 = readsRs2(op) ? modelRead(b, wb, wreg, wdata) : 32'd0;
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (wb && wreg != 5'd0) begin
      model[wreg] = wdata;
    end
    checkOutput("pc", oSignals.pc, expSignals.pc);
    checkOutput("insn", oSignals.insn, expSignals.insn);
    checkOutput("reg1", oSignals.reg1, expSignals.reg1);
    checkOutput("reg2", oSignals.reg2, expSignals.reg2);
    checkOutput("debug", oDebug, model[10]);
  endtask

  task automatic checkArray(input string tag);
    for (int i = 0; i < 32; i++) checkOutput(tag, dut.registers[i], model[i]);
  endtask

  initial begin
    logic [31:0] rnd, pcVal;
    logic [31:0] rawExpect;
    rst = 1'b1;
    stall = 1'b0;
    iBuffer = '0;
    wbIf.i_wback = 1'b0;
    wbIf.i_wreg = '0;
    wbIf.i_wdata = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    $display("[TB] reset and preload");
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("rst_reg1", oSignals.reg1, 32'd0);
    checkArray("rst_array");
    for (int i = 1; i < 32; i++) applyStimulus(0, 0, 32'h0, 32'h0, 1, 5'(i), 32'(i));

    $display("[TB] directed reads");
    applyStimulus(0, 0, 32'h100, 32'h00946FB3, 0, 0, 0);
    checkOutput("or_reg1", oSignals.reg1, 32'd8);
    checkOutput("or_reg2", oSignals.reg2, 32'd9);
    applyStimulus(0, 0, 32'h104, 32'h0031EF93, 0, 0, 0);
    checkOutput("ori_reg1", oSignals.reg1, 32'd3);
    checkOutput("ori_reg2", oSignals.reg2, 32'd0);
    applyStimulus(0, 0, 32'h108, 32'h000E8067, 0, 0, 0);
    checkOutput("jalr_reg1", oSignals.reg1, 32'd29);
    checkOutput("jalr_reg2", oSignals.reg2, 32'd0);
    applyStimulus(0, 0, 32'h10C, 32'h01E28263, 0, 0, 0);
    checkOutput("beq_reg1", oSignals.reg1, 32'd5);
    checkOutput("beq_reg2", oSignals.reg2, 32'd30);
    applyStimulus(0, 0, 32'h110, 32'h12345FB7, 0, 0, 0);
    checkOutput("lui_reg1", oSignals.reg1, 32'd0);
    checkOutput("lui_reg2", oSignals.reg2, 32'd0);

    $display("[TB] reset priority over write and stall");
    applyStimulus(1, 1, 32'h114, 32'h00946FB3, 1, 5'd10, 32'hDEAD);
    checkOutput("rst_insn", oSignals.insn, 32'd0);
    checkOutput("rst_debug", oDebug, 32'd0);
    checkArray("rst2_array");

    $display("[TB] writeback and x0");
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 5'd10, 32'd6725);
    checkOutput("wb_x10", dut.registers[10], 32'd6725);
    checkOutput("wb_debug", oDebug, 32'd6725);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
    checkOutput("x0_zero", dut.registers[0], 32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 5'd8, 32'd8);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 5'd9, 32'd9);

    $display("[TB] read during write");
`ifdef REGFILE_BYPASS_EN
    rawExpect = 32'h0000ABCD;
`else
    rawExpect = 32'd8;
`endif
    applyStimulus(0, 0, 32'h200, 32'h00946FB3, 1, 5'd8, 32'h0000ABCD);
    checkOutput("raw_reg1", oSignals.reg1, rawExpect);
    checkOutput("raw_x8", dut.registers[8], 32'h0000ABCD);

    $display("[TB] stall holds output");
    applyStimulus(0, 0, 32'h300, 32'h0031EF93, 0, 0, 0);
    applyStimulus(0, 1, 32'h304, 32'h01E28263, 1, 5'd12, 32'h55);
    checkOutput("stall_insn", oSignals.insn, 32'h0031EF93);
    checkOutput("stall_x12", dut.registers[12], 32'h55);

    $display("[TB] randomized cycles");
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      pcVal = $urandom();
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), pcVal,
                    {rnd[31:7], opList[$urandom_range(0, 10)]},
                    ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom());
      if (n % 100 == 99) checkArray("rand_array");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
